hex_display_controller: RTL and testbench
=========================================

HEX_DISPLAY_CONTROLLER -- requirements
Module: hex_display_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: number of seven-segment digits driven, legal range 1..8.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clock cycles per blink half-period, legal minimum 2.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 = segment lit by driving 0, 0 = segment lit by driving 1.
REQ-004 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port load_valid, input, 1: load_data offered for display.
REQ-007 SHALL have port load_ready, output, 1: block can accept a load this cycle.
REQ-008 SHALL have port load_data, input, 4*NUM_DIGITS: hex nibbles, digit i = bits [4i+3:4i], digit 0 least significant.
REQ-009 SHALL have port blank_lz, input, 1: leading-zero blanking enable, sampled with load_data.
REQ-010 SHALL have port blink_en, input, 1: blink all digits while high.
REQ-011 SHALL have port digit_en, input, NUM_DIGITS: per-digit enable, 0 forces that digit off.
REQ-012 SHALL have port seg_out, output, 7*NUM_DIGITS: digit i on bits [7i+6:7i], order {g,f,e,d,c,b,a}.

Function
REQ-013 SHALL accept a load on a rising edge where load_valid and load_ready are both 1, capturing load_data and blank_lz into a shadow register.
REQ-014 SHALL drive load_ready = 1 only in state IDLE; load_valid outside IDLE SHALL be ignored and capture nothing.
REQ-015 SHALL implement FSM IDLE -> SCAN (on accepted load) -> COMMIT (after NUM_DIGITS SCAN cycles) -> IDLE (after one cycle).
REQ-016 SHALL in SCAN examine one digit per cycle from digit NUM_DIGITS-1 down to digit 1, building a blank mask: digit i blanked iff captured blank_lz=1 and digits NUM_DIGITS-1..i are all zero; digit 0 never blanked.
REQ-017 SHALL in COMMIT copy the shadow nibbles and blank mask atomically into the display registers; the display SHALL never show a partially scanned value.
REQ-018 SHALL encode nibbles (active-high, hex {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-019 SHALL register seg_out: each cycle seg_out is computed from display registers, blank mask, digit_en and blink phase, giving one cycle of latency from those inputs.
REQ-020 SHALL drive a digit "off" (all segments unlit) when blanked, digit_en[i]=0, or blink_en=1 and blink phase=1.
REQ-021 SHALL invert the encoded pattern when ACTIVE_LOW=1 and pass it unchanged when ACTIVE_LOW=0.
REQ-022 SHALL update seg_out with new data on the edge after the COMMIT edge: load accepted at edge T, display registers load at edge T+NUM_DIGITS+1, seg_out shows them after edge T+NUM_DIGITS+2; load_ready low for exactly NUM_DIGITS+1 cycles.
REQ-023 SHALL run a free-running blink counter 0..BLINK_DIV-1, toggling blink phase on wrap, independent of blink_en.
REQ-024 SHALL keep all digits off after reset until the first COMMIT.

Reset
REQ-025 SHALL on rst_n=0 at a rising edge force: state IDLE, shadow and display registers 0, blank mask all set, blink counter 0, blink phase 0, seg_out all-off (all ones for ACTIVE_LOW=1).
REQ-026 SHALL hold load_ready = 0 while rst_n=0 and 1 in the first cycle after release.
REQ-027 SHALL abort any SCAN or COMMIT on reset with no partial update of display registers.

Verification (NUM_DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1, digit_en=6'b111111, blink_en=0 unless stated)
REQ-028 SHALL verify reset: hold rst_n=0 2 cycles -> seg_out=42'h3FF_FFFF_FFFF, load_ready=0; release -> load_ready=1 next cycle.
REQ-029 SHALL verify load 24'h00A05F, blank_lz=1 -> after 8 edges digits 5,4 = 7F, digit3=08, digit2=40, digit1=12, digit0=0E; load_ready low exactly 7 cycles.
REQ-030 SHALL verify load 24'h000000, blank_lz=1 -> digits 5..1 = 7F, digit0=40; same with blank_lz=0 -> all digits 40.
REQ-031 SHALL verify load_valid held high with different data during SCAN -> second value not captured, displayed value equals first load.
REQ-032 SHALL verify blink_en=1 after a commit -> seg_out alternates displayed value / all ones every 4 cycles; digit_en[2]=0 -> digit2=7F one cycle later.
REQ-033 SHALL verify rst_n=0 for one cycle mid-SCAN -> seg_out all ones, next load completes normally with REQ-022 timing.

Source files
------------

// File: rtl/hex_display_controller.sv
// Multi-digit seven-segment controller: a load is scanned for leading zeros in a
// shadow copy, then committed atomically to the display registers with optional blink.
module hex_display_controller #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [7*NUM_DIGITS-1:0] seg_out
);

    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNTW = $clog2(BLINK_DIV);
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_DIGITS - 1);
    localparam logic [CNTW-1:0] BLINK_LAST = CNTW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } stateT;

    stateT                   state;
    stateT                   nextState;
    logic [4*NUM_DIGITS-1:0] shadowData;
    logic [4*NUM_DIGITS-1:0] dispData;
    logic [NUM_DIGITS-1:0]   scanMask;
    logic [NUM_DIGITS-1:0]   dispMask;
    logic                    zeroRun;
    logic [IDXW-1:0]         scanIdx;
    logic [3:0]              scanNibble;
    logic [CNTW-1:0]         blinkCount;
    logic                    blinkPhase;
    logic                    loadAccept;
    logic [7*NUM_DIGITS-1:0] segNext;

    function automatic logic [6:0] encodeHex(input logic [3:0] nib);
        case (nib)
            4'h0: encodeHex = 7'h3F;
            4'h1: encodeHex = 7'h06;
            4'h2: encodeHex = 7'h5B;
            4'h3: encodeHex = 7'h4F;
            4'h4: encodeHex = 7'h66;
            4'h5: encodeHex = 7'h6D;
            4'h6: encodeHex = 7'h7D;
            4'h7: encodeHex = 7'h07;
            4'h8: encodeHex = 7'h7F;
            4'h9: encodeHex = 7'h6F;
            4'hA: encodeHex = 7'h77;
            4'hB: encodeHex = 7'h7C;
            4'hC: encodeHex = 7'h39;
            4'hD: encodeHex = 7'h5E;
            4'hE: encodeHex = 7'h79;
            default: encodeHex = 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] digitPattern(input logic [3:0] nib, input logic off);
        logic [6:0] pat;
        pat = off ? 7'h00 : encodeHex(nib);
        digitPattern = ACTIVE_LOW ? ~pat : pat;
    endfunction

    assign load_ready = rst_n && (state == IDLE);
    assign loadAccept = load_valid && load_ready;

    always_comb begin
        scanNibble = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scanIdx == IDXW'(i)) begin
                scanNibble = shadowData[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (loadAccept) nextState = SCAN;
            SCAN:    if (scanIdx == '0) nextState = COMMIT;
            COMMIT:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Scan walks from the top digit down; zeroRun stays set only while every digit seen so far is zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadowData <= '0;
            dispData   <= '0;
            scanMask   <= '1;
            dispMask   <= '1;
            zeroRun    <= 1'b0;
            scanIdx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (loadAccept) begin
                        shadowData <= load_data;
                        zeroRun    <= blank_lz;
                        scanIdx    <= LAST_IDX;
                        scanMask   <= '0;
                    end
                end
                SCAN: begin
                    if (scanIdx != '0) begin
                        scanMask[scanIdx] <= zeroRun && (scanNibble == 4'h0);
                        zeroRun           <= zeroRun && (scanNibble == 4'h0);
                        scanIdx           <= scanIdx - IDXW'(1);
                    end
                end
                COMMIT: begin
                    dispData <= shadowData;
                    dispMask <= scanMask;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blinkCount <= '0;
            blinkPhase <= 1'b0;
        end else if (blinkCount == BLINK_LAST) begin
            blinkCount <= '0;
            blinkPhase <= ~blinkPhase;
        end else begin
            blinkCount <= blinkCount + CNTW'(1);
        end
    end

    always_comb begin
        segNext = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            segNext[7*i +: 7] = digitPattern(dispData[4*i +: 4],
                                             dispMask[i] || !digit_en[i] || (blink_en && blinkPhase));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_out <= {(7*NUM_DIGITS){ACTIVE_LOW}};
        end else begin
            seg_out <= segNext;
        end
    end

endmodule

// File: tb/tb_hex_display_controller.sv
// Self-checking bench for hex_display_controller (6 digits, blink period 4, active-low):
// expected segment images are queued at load time and compared when they reach seg_out.
module tb_hex_display_controller;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [4*N-1:0] load_data = '0;
    logic          blank_lz = 1'b0;
    logic          blink_en = 1'b0;
    logic [N-1:0]  digit_en = 6'h3F;
    logic [7*N-1:0] seg_out;

    int testCount = 0;
    int failCount = 0;
    logic [7*N-1:0] expQ[$];
    logic [7*N-1:0] prevExp = '1;
    logic [4*N-1:0] lastData = '0;
    logic           lastBlz = 1'b0;

    localparam logic [6:0] ENC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex_display_controller #(
        .NUM_DIGITS(N),
        .BLINK_DIV (4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .digit_en  (digit_en),
        .seg_out   (seg_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7*N-1:0] modelSeg(input logic [4*N-1:0] d, input logic blz,
                                                input logic [N-1:0] den, input logic blinkOff);
        logic       zr;
        logic       blanked;
        logic [3:0] nib;
        logic [6:0] pat;
        logic [7*N-1:0] img;
        zr = blz;
        img = '0;
        for (int i = N - 1; i >= 0; i--) begin
            nib = d[4*i +: 4];
            blanked = (i != 0) && zr && (nib == 4'h0);
            zr = zr && (nib == 4'h0);
            pat = (blanked || !den[i] || blinkOff) ? 7'h00 : ENC[nib];
            img[7*i +: 7] = ~pat;
        end
        return img;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7*N-1:0] obs, input logic [7*N-1:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one load, tracks the ready-low window and checks old/new display around the commit.
    task automatic applyStimulus(input logic [4*N-1:0] data, input logic blz,
                                 input logic holdValid, input logic [4*N-1:0] altData);
        int w;
        int low;
        logic [7*N-1:0] exp;
        w = 0;
        low = 0;
        while (!load_ready && w < 20) begin
            tick();
            w++;
        end
        checkOutput("ready_before_load", {{(7*N-1){1'b0}}, load_ready}, 42'd1);
        load_data = data;
        blank_lz = blz;
        load_valid = 1'b1;
        expQ.push_back(modelSeg(data, blz, 6'h3F, 1'b0));
        tick();
        if (holdValid) begin
            load_data = altData;
            blank_lz = ~blz;
        end else begin
            load_valid = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 7) load_valid = 1'b0;
            if (!load_ready) low++;
            if (k == 7) checkOutput("seg_before_commit", seg_out, prevExp);
            tick();
        end
        checkOutput("ready_low_cycles", 42'(low), 42'(N + 1));
        if (expQ.size() == 0) begin
            checkOutput("queue_nonempty", 42'd0, 42'd1);
        end else begin
            exp = expQ.pop_front();
            checkOutput("seg_after_commit", seg_out, exp);
            prevExp = exp;
        end
        lastData = data;
        lastBlz = blz;
    endtask

    initial begin
        logic [7*N-1:0] dispImg;
        logic [7*N-1:0] offImg;
        logic [7*N-1:0] first;
        logic [7*N-1:0] startVal;
        logic [7*N-1:0] otherVal;
        int w;

        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset_seg", seg_out, 42'h3FF_FFFF_FFFF);
        checkOutput("reset_ready", {{(7*N-1){1'b0}}, load_ready}, 42'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("ready_after_release", {{(7*N-1){1'b0}}, load_ready}, 42'd1);

        applyStimulus(24'h00A05F, 1'b1, 1'b0, '0);
        checkOutput("digits_00A05F", seg_out, {7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12, 7'h0E});
        applyStimulus(24'h000000, 1'b1, 1'b0, '0);
        checkOutput("zero_blanked", seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        applyStimulus(24'h000000, 1'b0, 1'b0, '0);
        checkOutput("zero_unblanked", seg_out, {6{7'h40}});
        applyStimulus(24'h123456, 1'b0, 1'b1, 24'h0789AB);
        applyStimulus(24'h00000F, 1'b1, 1'b0, '0);

        dispImg = modelSeg(lastData, lastBlz, 6'h3F, 1'b0);
        offImg = '1;
        blink_en = 1'b1;
        tick();
        first = seg_out;
        checkOutput("blink_first_valid", {{(7*N-1){1'b0}}, (first === dispImg) || (first === offImg)}, 42'd1);
        w = 0;
        while (seg_out === first && w < 6) begin
            tick();
            w++;
        end
        checkOutput("blink_toggle_seen", {{(7*N-1){1'b0}}, (w < 6)}, 42'd1);
        startVal = (first === dispImg) ? offImg : dispImg;
        otherVal = (first === dispImg) ? dispImg : offImg;
        for (int m = 0; m < 12; m++) begin
            checkOutput("blink_phase", seg_out, (((m / 4) % 2) == 0) ? startVal : otherVal);
            tick();
        end

        blink_en = 1'b0;
        digit_en = 6'b111011;
        tick();
        checkOutput("digit2_disabled", seg_out, modelSeg(lastData, lastBlz, 6'b111011, 1'b0));
        digit_en = 6'h3F;
        tick();
        checkOutput("digit2_enabled", seg_out, dispImg);

        w = 0;
        while (!load_ready && w < 20) begin
            tick();
            w++;
        end
        load_data = 24'h111111;
        blank_lz = 1'b0;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("midscan_reset_seg", seg_out, 42'h3FF_FFFF_FFFF);
        checkOutput("midscan_reset_ready", {{(7*N-1){1'b0}}, load_ready}, 42'd0);
        rst_n = 1'b1;
        prevExp = '1;
        tick();
        checkOutput("post_reset_still_off", seg_out, 42'h3FF_FFFF_FFFF);
        applyStimulus(24'h00C3D0, 1'b1, 1'b0, '0);
        checkOutput("digits_00C3D0", seg_out, {7'h7F, 7'h7F, 7'h46, 7'h30, 7'h21, 7'h40});

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
